// File: rtl/mem_arbiter_if.sv
// Requester-side port of the memory arbiter: one request/ack handshake
// carrying a single 16-bit read or write.
interface mem_arbiter_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;

    // A requester drives the request fields and waits for ack.
    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    // The arbiter samples the request fields and returns ack/rdata.
    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the Hack memory-mapped bus. Port A (CPU data port)
// has fixed priority. Port B (loader / debug bridge) is forced through
// after STARVE_LIMIT consecutive lost arbitrations. One transaction at a
// time, always IDLE -> BUS -> RESP -> IDLE.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | sample requests, pick owner, latch its command onto the bus
// BUS   | address/data/write strobe presented to the decoder
// RESP  | strobe dropped, read-back valid, owner acked for one cycle
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave port_a,
    mem_arbiter_if.slave port_b,
    output logic [15:0]  mem_address,
    output logic         mem_load,
    output logic [15:0]  mem_wdata,
    input  logic [15:0]  mem_rdata,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    logic       owner_b;
    logic [3:0] starve_cnt;
    logic       any_req;
    logic       grant_b;

    // B wins when it is alone, or when it has lost LIMIT times in a row.
    assign any_req = port_a.req | port_b.req;
    assign grant_b = port_b.req & (~port_a.req | (starve_cnt == LIMIT));

    // Read-back is steered only to the port currently being acked.
    assign port_a.rdata = port_a.ack ? mem_rdata : 16'h0000;
    assign port_b.rdata = port_b.ack ? mem_rdata : 16'h0000;

    // Arbitration FSM; the bus command is copied at grant so requester
    // changes after that point cannot disturb the transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner_b     <= 1'b0;
            starve_cnt  <= 4'd0;
            mem_address <= 16'h0000;
            mem_load    <= 1'b0;
            mem_wdata   <= 16'h0000;
            busy        <= 1'b0;
            port_a.ack  <= 1'b0;
            port_b.ack  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_b     <= grant_b;
                        mem_address <= grant_b ? port_b.addr  : port_a.addr;
                        mem_load    <= grant_b ? port_b.we    : port_a.we;
                        mem_wdata   <= grant_b ? port_b.wdata : port_a.wdata;
                        busy        <= 1'b1;
                        state       <= BUS;
                    end
                    // Only an uninterrupted run of B losses counts toward the limit.
                    if (grant_b || !port_b.req) begin
                        starve_cnt <= 4'd0;
                    end else if (starve_cnt != LIMIT) begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                BUS: begin
                    mem_load   <= 1'b0;
                    port_a.ack <= ~owner_b;
                    port_b.ack <= owner_b;
                    state      <= RESP;
                end
                RESP: begin
                    port_a.ack <= 1'b0;
                    port_b.ack <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: queued requester transactions per port, a
// transaction-level reference (arbiter free time, loss count, reference
// memory) that predicts every output per cycle, plus directed scenarios.
module tb_mem_arbiter;

    localparam int LIMIT = 4;
    localparam int MAXC  = 20000;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          gap;
        bit          glitch;
        int          drop;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_address;
    logic        mem_load;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    mem_arbiter_if pa ();
    mem_arbiter_if pb ();

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .port_a      (pa),
        .port_b      (pb),
        .mem_address (mem_address),
        .mem_load    (mem_load),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Downstream decoder + RAM/peripheral stand-in.
    logic [15:0] bus_mem [0:65535];
    assign mem_rdata = bus_mem[mem_address];
    always @(posedge clk) if (mem_load) bus_mem[mem_address] <= mem_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    // reference state
    int          cyc = 0;
    int          free_c;
    int          lost;
    int          bloss;
    bit          act [2];
    bit          loaded [2];
    bit          dropped [2];
    int          waitc [2];
    int          ack_c [2];
    int          grant_c [2];
    txn_t        cur [2];
    txn_t        qa [$];
    txn_t        qb [$];
    int          olog [$];
    logic [15:0] ref_mem [0:65535];
    bit          ref_valid [0:65535];

    bit          e_acka [MAXC];
    bit          e_ackb [MAXC];
    bit          e_load [MAXC];
    bit          e_busy [MAXC];
    bit          e_rdchk [MAXC];
    logic [15:0] e_addr [MAXC];
    logic [15:0] e_wd [MAXC];
    logic [15:0] e_rd [MAXC];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic txn_t mk(input bit we, input logic [15:0] addr, input logic [15:0] wd,
                                input int gap, input bit glitch, input int drop);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wd; t.gap = gap; t.glitch = glitch; t.drop = drop;
        return t;
    endfunction

    function automatic logic [15:0] rand_addr();
        logic [15:0] idx;
        idx = 16'($urandom_range(0, 15));
        return ($urandom_range(0, 1) == 1) ? (16'h2000 + idx) : idx;
    endfunction

    task automatic drive_port(input int p, input bit rq, input bit we,
                              input logic [15:0] ad, input logic [15:0] wd);
        if (p == 0) begin
            pa.req = rq; pa.we = we; pa.addr = ad; pa.wdata = wd;
        end else begin
            pb.req = rq; pb.we = we; pb.addr = ad; pb.wdata = wd;
        end
    endtask

    task automatic model_reset();
        foreach (e_acka[i]) begin
            e_acka[i] = 0; e_ackb[i] = 0; e_load[i] = 0; e_busy[i] = 0; e_rdchk[i] = 0;
            e_addr[i] = 16'h0; e_wd[i] = 16'h0; e_rd[i] = 16'h0;
        end
        free_c = cyc + 1;
        lost = 0;
        bloss = 0;
        for (int p = 0; p < 2; p++) begin
            act[p] = 0; loaded[p] = 0; dropped[p] = 0; waitc[p] = 0;
            ack_c[p] = -1; grant_c[p] = -1;
        end
        qa.delete();
        qb.delete();
    endtask

    task automatic step();
        bit          rq [2];
        int          win;
        logic [15:0] a;
        logic [15:0] wd;
        @(posedge clk); #1;
        cyc++;
        // outputs of this cycle versus the prediction
        chk("a_ack", 16'(pa.ack), 16'(e_acka[cyc]));
        chk("b_ack", 16'(pb.ack), 16'(e_ackb[cyc]));
        chk("mem_load", 16'(mem_load), 16'(e_load[cyc]));
        chk("busy", 16'(busy), 16'(e_busy[cyc]));
        if (e_busy[cyc]) chk("mem_address", mem_address, e_addr[cyc]);
        if (e_load[cyc]) chk("mem_wdata", mem_wdata, e_wd[cyc]);
        if (e_acka[cyc] && e_rdchk[cyc]) chk("a_rdata", pa.rdata, e_rd[cyc]);
        if (e_ackb[cyc] && e_rdchk[cyc]) chk("b_rdata", pb.rdata, e_rd[cyc]);
        if (!e_acka[cyc]) chk("a_rdata_idle", pa.rdata, 16'h0);
        if (!e_ackb[cyc]) chk("b_rdata_idle", pb.rdata, 16'h0);
        if (pa.ack) olog.push_back(0);
        if (pb.ack) olog.push_back(1);

        // requesters: hold through ack, next command may start right after
        for (int p = 0; p < 2; p++) begin
            if (act[p] && ack_c[p] == cyc - 1) act[p] = 0;
            if (!act[p] && !loaded[p]) begin
                if (p == 0 && qa.size() > 0) begin
                    cur[0] = qa.pop_front(); loaded[0] = 1; waitc[0] = cur[0].gap;
                end else if (p == 1 && qb.size() > 0) begin
                    cur[1] = qb.pop_front(); loaded[1] = 1; waitc[1] = cur[1].gap;
                end
            end
            if (!act[p] && loaded[p]) begin
                if (waitc[p] == 0) begin
                    act[p] = 1; loaded[p] = 0; dropped[p] = 0;
                    ack_c[p] = -1; grant_c[p] = -1;
                    if (p == 1) bloss = 0;
                end else begin
                    waitc[p]--;
                end
            end
            rq[p] = act[p];
        end
        if (act[1] && cur[1].drop > 0 && !dropped[1] && bloss == cur[1].drop && cyc >= free_c) begin
            rq[1] = 0;
            dropped[1] = 1;
        end
        for (int p = 0; p < 2; p++) begin
            if (rq[p]) begin
                a  = cur[p].addr;
                wd = cur[p].wdata;
                if (cur[p].glitch && grant_c[p] == cyc - 1) begin
                    a  = a + 16'h1;
                    wd = ~wd;
                end
                drive_port(p, 1'b1, cur[p].we, a, wd);
            end else begin
                drive_port(p, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
            end
        end

        // arbitration decision of this idle cycle
        if (cyc >= free_c) begin
            if (rq[0] || rq[1]) begin
                if (rq[0] && rq[1]) win = (lost == LIMIT) ? 1 : 0;
                else win = rq[1] ? 1 : 0;
                if (!rq[1] || win == 1) lost = 0;
                else if (lost < LIMIT) lost++;
                if (rq[1] && win == 0) bloss++;
                a = cur[win].addr;
                e_load[cyc + 1] = cur[win].we;
                e_wd[cyc + 1]   = cur[win].wdata;
                e_addr[cyc + 1] = a;
                e_addr[cyc + 2] = a;
                e_busy[cyc + 1] = 1;
                e_busy[cyc + 2] = 1;
                if (win == 0) e_acka[cyc + 2] = 1;
                else e_ackb[cyc + 2] = 1;
                if (cur[win].we) begin
                    ref_mem[a] = cur[win].wdata;
                    ref_valid[a] = 1;
                end else if (ref_valid[a]) begin
                    e_rdchk[cyc + 2] = 1;
                    e_rd[cyc + 2] = ref_mem[a];
                end
                ack_c[win] = cyc + 2;
                grant_c[win] = cyc;
                free_c = cyc + 3;
            end else begin
                lost = 0;
            end
        end
    endtask

    task automatic run_txns(input int bound);
        int n;
        n = 0;
        while ((qa.size() > 0 || qb.size() > 0 || act[0] || act[1] || loaded[0] || loaded[1]
                || cyc < free_c) && n < bound) begin
            step();
            n++;
        end
        if (n >= bound) chk("run_timeout", 16'(n), 16'(bound - 1));
    endtask

    initial begin
        int pat_cont [10];
        int pat_starve [8];
        pat_cont   = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        pat_starve = '{0, 0, 0, 0, 0, 0, 0, 1};

        reset = 1'b1;
        drive_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive_port(1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_address", mem_address, 16'h0);
        chk("rst_mem_load", 16'(mem_load), 16'h0);
        chk("rst_mem_wdata", mem_wdata, 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_a_ack", 16'(pa.ack), 16'h0);
        chk("rst_b_ack", 16'(pb.ack), 16'h0);
        chk("rst_a_rdata", pa.rdata, 16'h0);
        chk("rst_b_rdata", pb.rdata, 16'h0);
        @(negedge clk) reset = 1'b0;
        model_reset();

        // A write then read back
        qa.push_back(mk(1'b1, 16'h0010, 16'hBEEF, 0, 1'b0, 0));
        qa.push_back(mk(1'b0, 16'h0010, 16'h0000, 2, 1'b0, 0));
        run_txns(100);

        // B peripheral write
        qb.push_back(mk(1'b1, 16'h2003, 16'h00A5, 0, 1'b0, 0));
        run_txns(100);

        // continuous contention
        olog.delete();
        for (int i = 0; i < 12; i++) qa.push_back(mk(1'b1, rand_addr(), 16'($urandom), 0, 1'b0, 0));
        for (int i = 0; i < 2; i++)  qb.push_back(mk(1'b0, rand_addr(), 16'h0, 0, 1'b0, 0));
        run_txns(200);
        for (int i = 0; i < 10; i++)
            chk("contention_order", 16'((olog.size() > i) ? olog[i] : 9), 16'(pat_cont[i]));

        // B drops its request after two losses, count must restart
        olog.delete();
        for (int i = 0; i < 10; i++) qa.push_back(mk(1'b0, rand_addr(), 16'h0, 0, 1'b0, 0));
        qb.push_back(mk(1'b1, 16'h2007, 16'h5A5A, 0, 1'b0, 2));
        run_txns(200);
        for (int i = 0; i < 8; i++)
            chk("starve_restart_order", 16'((olog.size() > i) ? olog[i] : 9), 16'(pat_starve[i]));

        // address changed by A during BUS
        qa.push_back(mk(1'b1, 16'h0005, 16'h1111, 0, 1'b1, 0));
        run_txns(100);

        // reset in the BUS cycle of a write
        @(posedge clk); #1;
        drive_port(0, 1'b1, 1'b1, 16'h0020, 16'h1234);
        drive_port(1, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;
        chk("midrst_bus_load", 16'(mem_load), 16'h1);
        #3 reset = 1'b1;
        #1;
        chk("midrst_load", 16'(mem_load), 16'h0);
        chk("midrst_busy", 16'(busy), 16'h0);
        chk("midrst_addr", mem_address, 16'h0);
        @(posedge clk); #1;
        chk("midrst_a_ack", 16'(pa.ack), 16'h0);
        drive_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        chk("postrst_a_ack", 16'(pa.ack), 16'h0);
        chk("postrst_busy", 16'(busy), 16'h0);
        model_reset();
        qa.push_back(mk(1'b0, 16'h0010, 16'h0000, 0, 1'b0, 0));
        qa.push_back(mk(1'b0, 16'h0020, 16'h0000, 0, 1'b0, 0));
        run_txns(100);

        // randomized traffic on both ports
        for (int i = 0; i < 200; i++) begin
            qa.push_back(mk(1'($urandom), rand_addr(), 16'($urandom), $urandom_range(0, 3),
                            ($urandom_range(0, 7) == 0), 0));
            qb.push_back(mk(1'($urandom), rand_addr(), 16'($urandom), $urandom_range(0, 3),
                            ($urandom_range(0, 7) == 0), 0));
        end
        run_txns(5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
